// File: rtl/onchip_mem_pkg.sv
// Shared constants, FSM state type and LFSR step function
// for the on-chip RAM built-in self test.
package onchip_mem_pkg;

    localparam int DEPTH = 98304;
    localparam int ADDR_W = 17;
    localparam int CNT_W = 18;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FINISH
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR pattern source; load has priority over step.
module lfsr32_galois
    import onchip_mem_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/onchip_mem_bist.sv
// Avalon-MM BIST master: LFSR fill, read-back and compare of
// a word range in the single-port on-chip RAM.
module onchip_mem_bist
    import onchip_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              param_err,
    output logic [ADDR_W-1:0] error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    localparam int RL = READ_LATENCY;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       seed_q, seed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              perr_q, perr_d;
    logic [ADDR_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic [RL-1:0]     vld_q, vld_d;
    logic [31:0]       exp_q [RL];
    logic [31:0]       exp_d [RL];
    logic [ADDR_W-1:0] adr_q [RL];
    logic [ADDR_W-1:0] adr_d [RL];

    logic              lfsr_load, lfsr_step;
    logic [31:0]       lfsr_seed, lfsr_val;
    logic [31:0]       seed_in;
    logic [ADDR_W-1:0] cur_addr;
    logic              last, range_bad, issue;

    lfsr32_galois u_lfsr (
        .clk   (clk),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign seed_in   = (seed == 32'h0) ? 32'h1 : seed;
    assign cur_addr  = base_q + cnt_q[ADDR_W-1:0];
    assign last      = (cnt_q == count_q - 1'b1);
    // 19-bit sum so that no base/count combination can wrap past DEPTH
    assign range_bad = ({2'b00, base_addr} + {1'b0, word_count})
                       > 19'(DEPTH);
    assign issue     = (state_q == READ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            vld_q   <= '0;
            for (int j = 0; j < RL; j++) begin
                exp_q[j] <= '0;
                adr_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            perr_q  <= perr_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            adr_q   <= adr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && word_count != '0 && !range_bad) begin
                    state_d = WRITE;
                end
            end
            WRITE:  if (last) state_d = READ;
            READ:   if (last) state_d = DRAIN;
            DRAIN:  if (cnt_q == CNT_W'(RL - 1)) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d    = base_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        perr_d    = perr_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        lfsr_seed = seed_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                        pass_d = 1'b1;
                        perr_d = 1'b0;
                        err_d  = '0;
                        ferr_d = '0;
                    end else if (range_bad) begin
                        done_d = 1'b1;
                        pass_d = 1'b0;
                        perr_d = 1'b1;
                    end else begin
                        base_d    = base_addr;
                        count_d   = word_count;
                        seed_d    = seed_in;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        pass_d    = 1'b0;
                        perr_d    = 1'b0;
                        err_d     = '0;
                        ferr_d    = '0;
                        lfsr_load = 1'b1;
                        lfsr_seed = seed_in;
                    end
                end
            end
            WRITE: begin
                if (last) begin
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    lfsr_step = 1'b1;
                end
            end
            READ: begin
                lfsr_step = 1'b1;
                cnt_d     = last ? '0 : cnt_q + 1'b1;
            end
            DRAIN: cnt_d = cnt_q + 1'b1;
            FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pass_d = (err_q == '0);
            end
            default: ;
        endcase

        vld_d    = '0;
        vld_d[0] = issue;
        exp_d    = exp_q;
        adr_d    = adr_q;
        exp_d[0] = lfsr_val;
        adr_d[0] = cur_addr;
        for (int j = 1; j < RL; j++) begin
            vld_d[j] = vld_q[j-1];
            exp_d[j] = exp_q[j-1];
            adr_d[j] = adr_q[j-1];
        end

        if (vld_q[RL-1] && mem_readdata != exp_q[RL-1]) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = adr_q[RL-1];
        end
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        unique case (state_q)
            WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = cur_addr;
                mem_writedata  = lfsr_val;
            end
            READ: begin
                mem_chipselect = 1'b1;
                mem_address    = cur_addr;
            end
            default: ;
        endcase
        mem_byteenable = mem_chipselect ? 4'hF : 4'h0;
    end

    assign mem_clken      = 1'b1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign param_err      = perr_q;
    assign error_count    = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: doc/onchip_mem_bist.md
Name: onchip_mem_bist

Overview:
- Avalon-MM master that sits directly upstream of the 32-bit single-port on-chip RAM slave (98304 words, 17-bit word address, byteenable, 1-cycle read latency).
- Fills a word range with a 32-bit LFSR pattern, reads the range back, and compares it against the regenerated pattern.
- Reports pass/fail, error count and first failing address.
- Used for board bring-up and post-configuration memory check before Golay codeword buffers are loaded.

Parameters:
- DEPTH, 98304, number of 32-bit words in the RAM.
- ADDR_W, 17, word address width.
- READ_LATENCY, 1, cycles from address presented to mem_readdata valid; values 1..2 supported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test when idle
- base_addr  in  17  first word address, sampled on start
- word_count  in  18  number of words to test, sampled on start (0..DEPTH)
- seed  in  32  LFSR seed, sampled on start; 0 is replaced by 32'h1
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  last test result; held until the next start
- param_err  out  1  last start was rejected because the range ran past DEPTH; held
- error_count  out  17  mismatching words in the last test
- first_err_addr  out  17  address of the first mismatch; 0 if none
- mem_address  out  17  to RAM address
- mem_byteenable  out  4  always 4'hF while chipselect is high, else 0
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  32  to RAM writedata
- mem_clken  out  1  tied 1
- mem_readdata  in  32  from RAM readdata

Behaviour:
- Reset values:
  - State IDLE.
  - busy, done, pass, param_err, mem_chipselect and mem_write are 0.
  - error_count, first_err_addr, mem_address and mem_writedata are 0.
  - mem_byteenable is 0.
- LFSR: Galois, taps 32'h80200003, shift right. Each step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0). The first word uses the seed value itself.
- States: IDLE -> WRITE -> READ -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - start with word_count==0: pulse done the next cycle, pass=1, error_count=0.
  - start with base_addr+word_count > DEPTH: pulse done, pass=0, param_err=1. No bus activity.
  - Otherwise: latch the inputs, clear the counters and param_err, set busy=1, go to WRITE.
- WRITE:
  - One write per cycle: chipselect=1, write=1, address=base+i, writedata=lfsr.
  - After word_count writes, reload lfsr with the seed and go to READ.
- READ:
  - One read per cycle: chipselect=1, write=0, address=base+i.
  - After the last read address is issued, go to DRAIN.
- DRAIN: wait READ_LATENCY cycles with chipselect=0.
- Compare pipeline:
  - A valid shift register of length READ_LATENCY tracks each read issue, along with its expected word and address.
  - When valid emerges, compare mem_readdata with the expected word.
  - On mismatch: error_count increments, saturating at 2^17-1. If it is the first error, capture first_err_addr.
  - Compares continue during READ and DRAIN, overlapped.
- FINISH:
  - Pulse done for one cycle; pass = (error_count==0); busy=0; go to IDLE.
  - Status outputs hold until the next accepted start.
- Boundaries:
  - A start while busy is ignored.
  - Last address = DEPTH-1 is legal, and no address wrap ever occurs.
  - word_count==DEPTH with base 0 is legal.
- Reset mid-test: on the next edge chipselect/write drop to 0 and all state returns to reset values. The RAM contents are left partially written.
- Throughput and latency: total cycles from start to done = 1 + 2*word_count + READ_LATENCY + 1.

Decomposition:
- Shared package onchip_mem_pkg:
  - DEPTH, ADDR_W, and LFSR_TAPS = 32'h80200003.
  - State enum {IDLE, WRITE, READ, DRAIN, FINISH}.
- Sub-module lfsr32_galois: inputs clk, load, seed, step; output value. It is instantiated once and reloaded between the WRITE and READ phases.

Test Plan:
- Behavioural RAM model with 1-cycle latency; base=0, count=16, seed=1 -> 16 writes then 16 reads; done 35 cycles after start; pass=1, error_count=0.
- Same test, with the model flipping bit 3 of word address 5 on read -> pass=0, error_count=1, first_err_addr=5.
- base=98300, count=4 -> legal, last address 98303, pass=1. base=98300, count=5 -> done next cycle, param_err=1, pass=0, chipselect never asserted.
- count=0 -> done one cycle after start, pass=1, no bus activity. seed=0 -> first writedata = 32'h1.
- start pulsed again during WRITE -> ignored. Then reset asserted in READ -> next cycle busy=0, chipselect=0, error_count=0. A fresh start afterwards completes normally.
- Model with stuck-zero data for count=8 and seed=32'hFFFFFFFF -> error_count=8, first_err_addr=base.
